// File: rtl/stopwatch_pkg.sv
// Shared state encoding and per-digit limits for the MM:SS stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam int SEC_U_MAX = 9;
  localparam int SEC_T_MAX = 5;
  localparam int MIN_U_MAX = 9;
  localparam int MIN_T_MAX = 9;

  // Digit index 0 is seconds units, 3 is minutes tens.
  function automatic int digit_max(input int idx);
    case (idx)
      0:       return SEC_U_MAX;
      1:       return SEC_T_MAX;
      2:       return MIN_U_MAX;
      default: return MIN_T_MAX;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One cascadable BCD digit: counts on en, wraps at MAX and signals carry.
module bcd_digit #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] value,
  output logic       carry_out
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  // ">=" rather than "==" so a corrupted digit still falls back into range.
  assign carry_out = en & (value >= MAX_V);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= 4'd0;
    end else if (clr) begin
      value <= 4'd0;
    end else if (en) begin
      value <= (value >= MAX_V) ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button decode FSM, 1 Hz prescaler, four cascaded BCD
// digits with a lap capture bank and a live/lap display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop_btn,
  input  logic       lap_btn,
  input  logic       clear_btn,
  output logic [3:0] disp_d0,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d3,
  output logic       running,
  output logic       frozen,
  output logic       rollover
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic          start_q_reg, lap_q_reg, clear_q_reg;
  logic          running_reg, frozen_reg, rollover_reg;
  logic          press_start, press_lap, press_clear;
  logic          active, tick, do_clear, do_capture;
  logic [3:0]    live_val [4];
  logic [3:0]    lap_reg  [4];
  logic [3:0]    digit_en;
  logic [3:0]    carry;

  assign press_start = start_stop_btn & ~start_q_reg;
  assign press_lap   = lap_btn & ~lap_q_reg;
  assign press_clear = clear_btn & ~clear_q_reg;

  assign active = (state_reg == RUN) || (state_reg == LAP);
  assign tick   = active && (presc_reg == PRESC_LAST);

  always_comb begin
    do_clear   = 1'b0;
    do_capture = 1'b0;
    if (state_reg == PAUSE) do_clear = press_clear;
    // Start outranks lap in RUN, so a simultaneous start suppresses the capture.
    if (state_reg == RUN) do_capture = press_lap & ~press_start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q_reg <= 1'b0;
      lap_q_reg   <= 1'b0;
      clear_q_reg <= 1'b0;
    end else begin
      start_q_reg <= start_stop_btn;
      lap_q_reg   <= lap_btn;
      clear_q_reg <= clear_btn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      running_reg <= 1'b0;
      frozen_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (press_start) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        RUN: begin
          if (press_start) begin
            state_reg   <= PAUSE;
            running_reg <= 1'b0;
          end else if (press_lap) begin
            state_reg  <= LAP;
            frozen_reg <= 1'b1;
          end
        end
        PAUSE: begin
          if (press_clear) begin
            state_reg <= IDLE;
          end else if (press_start) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        LAP: begin
          if (press_start) begin
            state_reg   <= PAUSE;
            running_reg <= 1'b0;
            frozen_reg  <= 1'b0;
          end else if (press_lap) begin
            state_reg  <= RUN;
            frozen_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
          frozen_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg    <= '0;
      rollover_reg <= 1'b0;
    end else begin
      if (active) begin
        presc_reg <= tick ? '0 : presc_reg + 1'b1;
      end else if (do_clear) begin
        presc_reg <= '0;
      end
      // Top-digit carry can only happen when every lower digit wrapped too.
      rollover_reg <= carry[3];
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        assign digit_en[gi] = tick;
      end else begin : g_chain
        assign digit_en[gi] = carry[gi-1];
      end

      bcd_digit #(
        .MAX(digit_max(gi))
      ) u_digit (
        .clk      (clk),
        .rst      (rst),
        .en       (digit_en[gi]),
        .clr      (do_clear),
        .value    (live_val[gi]),
        .carry_out(carry[gi])
      );

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lap_reg[gi] <= 4'd0;
        end else if (do_capture) begin
          lap_reg[gi] <= live_val[gi];
        end
      end
    end
  endgenerate

  assign disp_d0  = frozen_reg ? lap_reg[0] : live_val[0];
  assign disp_d1  = frozen_reg ? lap_reg[1] : live_val[1];
  assign disp_d2  = frozen_reg ? lap_reg[2] : live_val[2];
  assign disp_d3  = frozen_reg ? lap_reg[3] : live_val[3];
  assign running  = running_reg;
  assign frozen   = frozen_reg;
  assign rollover = rollover_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch bench: seconds-level behavioural model checked every cycle, plus
// directed scenarios with hand-computed display values.
module tb_stopwatch_ctrl;

  localparam int DIV    = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUS = 2;
  localparam int M_LAP  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ss_btn = 1'b0;
  logic       lap_btn = 1'b0;
  logic       clr_btn = 1'b0;
  logic [3:0] disp_d0, disp_d1, disp_d2, disp_d3;
  logic       running, frozen, rollover;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_DIV(DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_stop_btn(ss_btn),
    .lap_btn       (lap_btn),
    .clear_btn     (clr_btn),
    .disp_d0       (disp_d0),
    .disp_d1       (disp_d1),
    .disp_d2       (disp_d2),
    .disp_d3       (disp_d3),
    .running       (running),
    .frozen        (frozen),
    .rollover      (rollover)
  );

  // Model: elapsed time as total seconds, plus cycles into the current second.
  typedef struct packed {
    int   mode;
    int   secs;
    int   lap_secs;
    int   phase;
    logic roll;
  } model_t;

  model_t m;
  logic   p_ss, p_lap, p_clr;

  function automatic model_t step(input model_t cur, input logic ps, input logic pl,
                                  input logic pc);
    model_t n = cur;
    logic act = (cur.mode == M_RUN) || (cur.mode == M_LAP);
    logic tk  = act && (cur.phase == DIV - 1);
    n.roll = 1'b0;
    if (act) n.phase = tk ? 0 : cur.phase + 1;
    if (tk) begin
      if (cur.secs == 5999) begin
        n.secs = 0;
        n.roll = 1'b1;
      end else begin
        n.secs = cur.secs + 1;
      end
    end
    case (cur.mode)
      M_IDLE: if (ps) n.mode = M_RUN;
      M_RUN: begin
        if (ps) n.mode = M_PAUS;
        else if (pl) begin
          n.mode = M_LAP;
          n.lap_secs = cur.secs;
        end
      end
      M_PAUS: begin
        if (pc) begin
          n.mode = M_IDLE;
          n.secs = 0;
          n.phase = 0;
        end else if (ps) n.mode = M_RUN;
      end
      default: begin
        if (ps) n.mode = M_PAUS;
        else if (pl) n.mode = M_RUN;
      end
    endcase
    return n;
  endfunction

  function automatic int digit_of(input int s, input int idx);
    case (idx)
      0:       return s % 10;
      1:       return (s / 10) % 6;
      2:       return (s / 60) % 10;
      default: return s / 600;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m     <= '0;
      p_ss  <= 1'b0;
      p_lap <= 1'b0;
      p_clr <= 1'b0;
    end else begin
      m     <= step(m, ss_btn & ~p_ss, lap_btn & ~p_lap, clr_btn & ~p_clr);
      p_ss  <= ss_btn;
      p_lap <= lap_btn;
      p_clr <= clr_btn;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int shown;
    shown = (m.mode == M_LAP) ? m.lap_secs : m.secs;
    chk("model_d0", disp_d0, digit_of(shown, 0));
    chk("model_d1", disp_d1, digit_of(shown, 1));
    chk("model_d2", disp_d2, digit_of(shown, 2));
    chk("model_d3", disp_d3, digit_of(shown, 3));
    chk("model_running", running, (m.mode == M_RUN) || (m.mode == M_LAP));
    chk("model_frozen", frozen, m.mode == M_LAP);
    chk("model_rollover", rollover, m.roll);
    chk("d1_range", disp_d1 <= 4'd5, 1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask = {clear, lap, start}; returns 1 time unit after the sampling edge.
  task automatic press(input logic [2:0] mask);
    @(posedge clk);
    #1;
    {clr_btn, lap_btn, ss_btn} = mask;
    @(posedge clk);
    #1;
    {clr_btn, lap_btn, ss_btn} = 3'b000;
  endtask

  task automatic run_to(input int target);
    int budget = 200;
    while (!(m.secs == target && m.phase == 0 && (m.mode == M_RUN || m.mode == M_LAP))
           && budget > 0) begin
      cycles(1);
      budget--;
    end
    chk("run_to_in_time", budget > 0, 1);
  endtask

  task automatic chk_disp(input string name, input int d3, input int d2, input int d1,
                          input int d0);
    chk({name, "_d3"}, disp_d3, d3);
    chk({name, "_d2"}, disp_d2, d2);
    chk({name, "_d1"}, disp_d1, d1);
    chk({name, "_d0"}, disp_d0, d0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    chk_disp("in_reset", 0, 0, 0, 0);
    chk("in_reset_running", running, 0);
    rst = 1'b1;
    cycles(2);
    chk_disp("after_reset", 0, 0, 0, 0);
    chk("after_reset_running", running, 0);
    chk("after_reset_frozen", frozen, 0);
    chk("after_reset_rollover", rollover, 0);
    $display("txn reset released");

    press(3'b001);
    chk("start_running", running, 1);
    cycles(3);
    chk("first_tick_not_early", disp_d0, 0);
    cycles(1);
    chk("first_tick_on_time", disp_d0, 1);
    cycles(236);
    chk_disp("sixty_ticks", 0, 1, 0, 0);
    $display("txn start, 60 ticks -> 01:00");

    cycles(23756);
    chk_disp("max_count", 9, 9, 5, 9);
    cycles(4);
    chk_disp("wrapped", 0, 0, 0, 0);
    chk("wrap_rollover", rollover, 1);
    chk("wrap_running", running, 1);
    cycles(1);
    chk("rollover_one_cycle", rollover, 0);
    $display("txn 99:59 -> 00:00 rollover");

    run_to(7);
    press(3'b010);
    chk("lap_frozen", frozen, 1);
    chk_disp("lap_capture", 0, 0, 0, 7);
    run_to(12);
    chk_disp("lap_hold", 0, 0, 0, 7);
    press(3'b010);
    chk("unlap_frozen", frozen, 0);
    chk_disp("unlap_live", 0, 0, 1, 2);
    $display("txn lap at 00:07, release at 00:12");

    press(3'b001);
    press(3'b100);
    chk_disp("cleared", 0, 0, 0, 0);
    press(3'b001);
    run_to(3);
    press(3'b001);
    chk("pause_running", running, 0);
    cycles(20);
    chk_disp("pause_hold", 0, 0, 0, 3);
    press(3'b100);
    chk_disp("pause_clear", 0, 0, 0, 0);
    chk("clear_idle_running", running, 0);
    press(3'b001);
    cycles(3);
    chk("restart_not_early", disp_d0, 0);
    cycles(1);
    chk("restart_on_time", disp_d0, 1);
    $display("txn pause at 00:03, clear, restart");

    run_to(5);
    press(3'b100);
    chk("run_clear_ignored_running", running, 1);
    chk_disp("run_clear_ignored", 0, 0, 0, 5);
    run_to(6);
    chk_disp("run_continues", 0, 0, 0, 6);
    press(3'b001);
    press(3'b101);
    chk("clear_beats_start", running, 0);
    chk_disp("clear_beats_start", 0, 0, 0, 0);
    press(3'b001);
    chk("idle_to_run", running, 1);
    $display("txn clear ignored in RUN, clear+start in PAUSE");

    run_to(9);
    press(3'b010);
    chk_disp("lap_before_reset", 0, 0, 0, 9);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_disp("async_reset", 0, 0, 0, 0);
    chk("async_reset_running", running, 0);
    chk("async_reset_frozen", frozen, 0);
    chk("async_reset_rollover", rollover, 0);
    lap_btn = 1'b1;
    cycles(2);
    rst = 1'b1;
    cycles(5);
    chk("held_lap_idle", running, 0);
    chk_disp("held_lap_idle", 0, 0, 0, 0);
    lap_btn = 1'b0;
    cycles(2);
    press(3'b001);
    cycles(4);
    chk("post_reset_count_from_zero", disp_d0, 1);
    chk("post_reset_running", running, 1);
    $display("txn async reset in LAP at 00:09");

    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
